// File: rtl/fbuf_scanout.sv
// Framebuffer scan-out: replays the downscaled 12-bit framebuffer as upscaled 24-bit video with syncs.
// Optional FBUF_SCANOUT_BORDER_EN forces a white one-pixel frame around the active area.
module fbuf_scanout #(
  parameter int FRAME_WIDTH       = 1920,
  parameter int FRAME_HEIGHT      = 1080,
  parameter int SCALING_FACTOR    = 4,
  parameter int H_FRONT           = 88,
  parameter int H_SYNC            = 44,
  parameter int H_BACK            = 148,
  parameter int V_FRONT           = 4,
  parameter int V_SYNC            = 5,
  parameter int V_BACK            = 36,
  parameter bit SYNC_POL          = 1'b1,
  parameter int FBUF_READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] pixel_fbuf_rd_address,
  output logic        pixel_fbuf_rd_en,
  input  logic [11:0] pixel_fbuf_rd_data,
  output logic [23:0] vid_rgb,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic        frame_start
);

  localparam int H_TOTAL = FRAME_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = FRAME_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int SW      = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
  localparam int L       = FBUF_READ_LATENCY;
  localparam int P       = L + 2;

  localparam logic [HW-1:0] H_ACT      = HW'(FRAME_WIDTH);
  localparam logic [HW-1:0] H_LAST_ACT = HW'(FRAME_WIDTH - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(FRAME_WIDTH + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(FRAME_WIDTH + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACT      = VW'(FRAME_HEIGHT);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(FRAME_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(FRAME_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] S_LAST     = SW'(SCALING_FACTOR - 1);
  localparam logic [16:0]   LINE_STEP  = 17'(FRAME_WIDTH / SCALING_FACTOR);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [16:0]   addr_q, addr_d, line_base_q, line_base_d;
  logic [16:0]   rd_address_q, rd_address_d;
  logic          rd_en_q, rd_en_d;
  logic [P-1:0]  de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d;
  logic [P-1:0]  vs_pipe_q, vs_pipe_d, fs_pipe_q, fs_pipe_d;
  logic [23:0]   vid_rgb_q, vid_rgb_d;

  logic active_c, hs_c, vs_c, fs_c;

  assign active_c = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_c     = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_c     = (v_q >= VS_BEG) && (v_q < VS_END);
  assign fs_c     = (h_q == '0) && (v_q == '0);

`ifdef FBUF_SCANOUT_BORDER_EN
  logic         border_c;
  logic [L:0]   border_pipe_q, border_pipe_d;
  assign border_c = active_c && ((h_q == '0) || (h_q == H_LAST_ACT) ||
                                 (v_q == '0) || (v_q == VW'(FRAME_HEIGHT - 1)));
  assign border_pipe_d = {border_pipe_q[L-1:0], border_c};
`endif

  // Raster counters and incremental framebuffer addressing.
  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    h_d         = h_q + 1'b1;
    v_d         = v_q;
    sub_x_d     = sub_x_q;
    sub_y_d     = sub_y_q;
    addr_d      = addr_q;
    line_base_d = line_base_q;

    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    if (active_c) begin
      if (sub_x_q == S_LAST) begin
        sub_x_d = '0;
        addr_d  = addr_q + 17'd1;
      end else begin
        sub_x_d = sub_x_q + 1'b1;
      end
      // End of an active line: repeat the stored row SCALING_FACTOR times, then step down.
      if (h_q == H_LAST_ACT) begin
        if (sub_y_q == S_LAST) begin
          sub_y_d     = '0;
          line_base_d = line_base_q + LINE_STEP;
        end else begin
          sub_y_d = sub_y_q + 1'b1;
        end
        addr_d = line_base_d;
      end
    end

    if ((h_q == H_LAST) && (v_q == V_LAST)) begin
      sub_x_d     = '0;
      sub_y_d     = '0;
      addr_d      = '0;
      line_base_d = '0;
    end
  end

  assign rd_address_d = addr_q;
  assign rd_en_d      = active_c;
  assign de_pipe_d    = {de_pipe_q[P-2:0], active_c};
  assign hs_pipe_d    = {hs_pipe_q[P-2:0], hs_c};
  assign vs_pipe_d    = {vs_pipe_q[P-2:0], vs_c};
  assign fs_pipe_d    = {fs_pipe_q[P-2:0], fs_c};

  // Stage L of the de pipe lines up with rd_data; blanking data is discarded.
  always_comb begin
    vid_rgb_d = '0;
    if (de_pipe_q[L]) begin
      vid_rgb_d = {pixel_fbuf_rd_data[11:8], pixel_fbuf_rd_data[11:8],
                   pixel_fbuf_rd_data[7:4],  pixel_fbuf_rd_data[7:4],
                   pixel_fbuf_rd_data[3:0],  pixel_fbuf_rd_data[3:0]};
    end
`ifdef FBUF_SCANOUT_BORDER_EN
    if (de_pipe_q[L] && border_pipe_q[L]) begin
      vid_rgb_d = 24'hFF_FFFF;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      sub_x_q       <= '0;
      sub_y_q       <= '0;
      addr_q        <= '0;
      line_base_q   <= '0;
      rd_address_q  <= '0;
      rd_en_q       <= 1'b0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      fs_pipe_q     <= '0;
      vid_rgb_q     <= '0;
`ifdef FBUF_SCANOUT_BORDER_EN
      border_pipe_q <= '0;
`endif
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      sub_x_q       <= sub_x_d;
      sub_y_q       <= sub_y_d;
      addr_q        <= addr_d;
      line_base_q   <= line_base_d;
      rd_address_q  <= rd_address_d;
      rd_en_q       <= rd_en_d;
      de_pipe_q     <= de_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      fs_pipe_q     <= fs_pipe_d;
      vid_rgb_q     <= vid_rgb_d;
`ifdef FBUF_SCANOUT_BORDER_EN
      border_pipe_q <= border_pipe_d;
`endif
    end
  end

  assign pixel_fbuf_rd_address = rd_address_q;
  assign pixel_fbuf_rd_en      = rd_en_q;
  assign vid_rgb               = vid_rgb_q;
  assign vid_de                = de_pipe_q[P-1];
  assign frame_start           = fs_pipe_q[P-1];
  assign vid_hsync             = SYNC_POL ? hs_pipe_q[P-1] : ~hs_pipe_q[P-1];
  assign vid_vsync             = SYNC_POL ? vs_pipe_q[P-1] : ~vs_pipe_q[P-1];

endmodule
